sweep_ctrl: RTL

SWEEP_CTRL -- requirements
Module: sweep_ctrl

---
 rtl/sweep_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sweep_ctrl
// Description : Drives an external up/down counter through repeated triangle
//               sweeps between two latched limits. It watches the counter's
//               output to decide when to turn around, and flags a tracking
//               fault if the counter leaves the expected range.
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_ctrl #(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stop,
  input  logic [SIZE-1:0] lo_lim,
  input  logic [SIZE-1:0] hi_lim,
  input  logic [7:0]      num_cycles,
  input  logic [SIZE-1:0] cnt_in,
  output logic            load,
  output logic [SIZE-1:0] data,
  output logic            up_dwn,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [7:0]      cycle_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_UP    = 2'd2,
    S_DOWN  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] lo_q, lo_d;
  logic [SIZE-1:0] hi_q, hi_d;
  logic [7:0]      n_q, n_d;
  logic [7:0]      cyc_q, cyc_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // Turn-around points: the counter is one step short of the limit, so the
  // step taken on the turning edge lands exactly on the limit.
  logic [SIZE-1:0] hi_m1;
  logic [SIZE-1:0] lo_p1;
  logic            up_fault;
  logic            dn_fault;

  assign hi_m1    = hi_q - 1'b1;
  assign lo_p1    = lo_q + 1'b1;
  assign up_fault = (cnt_in < lo_q) || (cnt_in >= hi_q);
  assign dn_fault = (cnt_in <= lo_q) || (cnt_in > hi_q);

  // State and latched-parameter registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      n_q     <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: a fault outranks stop (it alone raises err), and stop
  // outranks the normal turn-around transitions.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    n_d     = n_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (hi_lim > lo_lim) begin
            lo_d    = lo_lim;
            hi_d    = hi_lim;
            n_d     = num_cycles;
            cyc_d   = '0;
            state_d = S_PRIME;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_PRIME: begin
        // One load cycle so the counter holds lo_q on the first UP cycle.
        state_d = stop ? S_IDLE : S_UP;
      end
      S_UP: begin
        if (up_fault) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (stop) begin
          state_d = S_IDLE;
        end else if (cnt_in == hi_m1) begin
          state_d = S_DOWN;
        end
      end
      S_DOWN: begin
        if (dn_fault) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (stop) begin
          state_d = S_IDLE;
        end else if (cnt_in == lo_p1) begin
          // Triangle complete; a zero target count means run forever.
          cyc_d = cyc_q + 8'd1;
          if ((n_q != 8'd0) && (cyc_d == n_q)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_UP;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Counter controls come from registered state only, never from inputs.
  assign load      = (state_q == S_IDLE) || (state_q == S_PRIME);
  assign up_dwn    = (state_q != S_DOWN);
  assign data      = lo_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign cycle_cnt = cyc_q;

endmodule
`default_nettype wire
